// File: rtl/tb_mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported simulation SRAM among NumPorts
// requesters. A fixed-latency shift pipeline routes each response back to the
// port that was granted.
module tb_mem_port_arbiter #(
    parameter int unsigned NumPorts   = 2,
    parameter int unsigned AddrWidth  = 48,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned MemLatency = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumPorts-1:0]             req_i,
    input  logic [NumPorts-1:0]             we_i,
    input  logic [NumPorts*AddrWidth-1:0]   addr_i,
    input  logic [NumPorts*DataWidth-1:0]   wdata_i,
    input  logic [NumPorts*DataWidth/8-1:0] be_i,
    output logic [NumPorts-1:0]             gnt_o,
    output logic [NumPorts-1:0]             rvalid_o,
    output logic [NumPorts*DataWidth-1:0]   rdata_o,
    output logic                            mem_req_o,
    output logic                            mem_we_o,
    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    output logic [DataWidth/8-1:0]          mem_be_o,
    input  logic [DataWidth-1:0]            mem_rdata_i
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned IdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0]   win, cand;
    logic                  grant;
    logic [MemLatency-1:0] pipe_vld_q;
    logic [IdxWidth-1:0]   pipe_idx_q [MemLatency];

    // Scan from rr_ptr upward with wrap; first requesting port wins.
    always_comb begin
        grant = 1'b0;
        win   = rr_ptr_q;
        cand  = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cand = IdxWidth'((32'(rr_ptr_q) + i) % NumPorts);
            if (!grant && req_i[cand]) begin
                grant = 1'b1;
                win   = cand;
            end
        end
    end

    // Grant vector, memory-side mux and next pointer.
    always_comb begin
        gnt_o       = '0;
        mem_req_o   = |req_i;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        rr_ptr_d    = rr_ptr_q;
        if (grant) begin
            gnt_o[win]  = 1'b1;
            mem_we_o    = we_i[win];
            mem_addr_o  = addr_i[32'(win)*AddrWidth +: AddrWidth];
            mem_wdata_o = wdata_i[32'(win)*DataWidth +: DataWidth];
            mem_be_o    = be_i[32'(win)*BeWidth +: BeWidth];
            rr_ptr_d    = (32'(win) == NumPorts - 1) ? '0 : win + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Latency pipeline of {valid, port}; reset drops in-flight responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < MemLatency; k++) begin
                pipe_idx_q[k] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= grant;
            pipe_idx_q[0] <= win;
            for (int k = 1; k < MemLatency; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_idx_q[k] <= pipe_idx_q[k-1];
            end
        end
    end

    // Route SRAM read data to the port owning the oldest in-flight request.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (pipe_vld_q[MemLatency-1]) begin
            rvalid_o[pipe_idx_q[MemLatency-1]] = 1'b1;
            rdata_o[32'(pipe_idx_q[MemLatency-1])*DataWidth +: DataWidth] = mem_rdata_i;
        end
    end

endmodule
